// File: rtl/frame_cmd_scheduler.sv
// Command FIFO that steers writes to the hidden buffer and defers flips to vblank.
// Optional macro DROP_COUNT_EN adds a saturating drop_count output.
module frame_cmd_scheduler #(
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 4,
    parameter int VBLANK_LINE = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cmd_in,
    input  logic              cmd_in_valid,
    output logic              cmd_in_ready,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              clr_status,
    output logic [31:0]       writedata,
    output logic              back_sel,
    output logic              flip_pending,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
`ifdef DROP_COUNT_EN
    output logic [15:0]       drop_count,
`endif
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_VBL,
        S_FLIP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_vbl_d;
    logic [31:0]       r_writedata;
    logic              r_back_sel;
    logic              r_overflow;
    logic [15:0]       r_frame_count;

    logic              w_full;
    logic              w_empty;
    logic [3:0]        w_info;
    logic              w_push_req;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_flip;
    logic [31:0]       w_head;
    logic [31:0]       w_wd_nxt;
    logic              w_in_vbl;
    logic              w_vbl_start;
    logic              w_unused_hcount;

    assign w_unused_hcount = ^hcount;

    assign w_full     = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_info     = cmd_in[20:17];
    assign w_push_req = cmd_in_valid &&
                        (w_info == 4'b0001 || w_info == 4'b1111);
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_head     = r_mem[r_rd_ptr];

    assign w_in_vbl    = (vcount >= 10'(VBLANK_LINE));
    assign w_vbl_start = w_in_vbl && !r_vbl_d;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_vbl_d       <= 1'b0;
            r_writedata   <= '0;
            r_back_sel    <= 1'b1;
            r_frame_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vbl_d     <= w_in_vbl;
            r_writedata <= w_wd_nxt;
            if (w_flip) begin
                r_back_sel    <= ~r_back_sel;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Flip words are consumed here and never reach the bus directly.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flip      = 1'b0;
        w_wd_nxt    = '0;
        case (r_state)
            S_RUN: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head[20:17] == 4'b1111) begin
                        w_state_nxt = S_WAIT_VBL;
                    end else begin
                        w_wd_nxt = {w_head[31:14], r_back_sel,
                                    w_head[12:0]};
                    end
                end
            end
            S_WAIT_VBL: begin
                if (w_vbl_start) begin
                    w_state_nxt = S_FLIP;
                end
            end
            S_FLIP: begin
                w_wd_nxt    = {6'b0, 5'b0, 4'b1111, 3'b0,
                               r_back_sel, 13'b0};
                w_flip      = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_status) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (clr_status) begin
            r_drop_count <= {15'b0, w_drop};
        end else if (w_drop && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign cmd_in_ready = !w_full;
    assign writedata    = r_writedata;
    assign back_sel     = r_back_sel;
    assign flip_pending = (r_state == S_WAIT_VBL);
    assign fifo_level   = r_count;
    assign overflow     = r_overflow;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Directed bench for frame_cmd_scheduler: latency, flips, overflow, reset.
module tb_frame_cmd_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cmd_in = '0;
    logic        cmd_in_valid = 1'b0;
    logic        cmd_in_ready;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = 10'd100;
    logic        clr_status = 1'b0;
    logic [31:0] writedata;
    logic        back_sel;
    logic        flip_pending;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] frame_count;
`ifdef DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int n_run = 0;
    int n_fail = 0;

    frame_cmd_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .hcount       (hcount),
        .vcount       (vcount),
        .clr_status   (clr_status),
        .writedata    (writedata),
        .back_sel     (back_sel),
        .flip_pending (flip_pending),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
`ifdef DROP_COUNT_EN
        .drop_count   (drop_count),
`endif
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hcount <= hcount + 10'd1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at the first negedge where writedata is non-zero.
    task automatic wait_wd(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (writedata !== 32'h0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic ok;
    int   nz;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wd", writedata, 32'h0);
        chk("rst_back", {31'b0, back_sel}, 32'd1);
        chk("rst_ready", {31'b0, cmd_in_ready}, 32'd1);
        chk("rst_level", {27'b0, fifo_level}, 32'd0);
        chk("rst_fc", {16'b0, frame_count}, 32'd0);
        chk("rst_pend", {31'b0, flip_pending}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b0;

        // three writes back to back
        @(negedge clk);
        cmd_in = 32'h28024000; cmd_in_valid = 1'b1;
        @(negedge clk);
        chk("lat_min", writedata, 32'h0);
        cmd_in = 32'h28028000;
        @(negedge clk);
        chk("wr0", writedata, 32'h28026000);
        cmd_in = 32'h2802C000;
        @(negedge clk);
        chk("wr1", writedata, 32'h2802A000);
        cmd_in_valid = 1'b0;
        @(negedge clk);
        chk("wr2", writedata, 32'h2802E000);
        @(negedge clk);
        chk("wr_idle", writedata, 32'h0);
        chk("wr_level", {27'b0, fifo_level}, 32'd0);

        // info=0010 must be filtered
        cmd_in = 32'h28040000; cmd_in_valid = 1'b1;
        @(negedge clk);
        cmd_in_valid = 1'b0;
        @(negedge clk);
        chk("filt_level", {27'b0, fifo_level}, 32'd0);
        chk("filt_wd", writedata, 32'h0);
        chk("filt_ovf", {31'b0, overflow}, 32'd0);

        // single flip
        cmd_in = 32'h001E0000; cmd_in_valid = 1'b1;
        @(negedge clk);
        cmd_in_valid = 1'b0;
        @(negedge clk);
        chk("flip_pend", {31'b0, flip_pending}, 32'd1);
        chk("flip_wd0", writedata, 32'h0);
        repeat (3) @(negedge clk);
        chk("flip_hold", {31'b0, flip_pending}, 32'd1);
        vcount = 10'd479;
        @(negedge clk);
        chk("flip_479", writedata, 32'h0);
        vcount = 10'd480;
        wait_wd(ok);
        chk("flip_seen", {31'b0, ok}, 32'd1);
        chk("flip_word", writedata, 32'h001E2000);
        chk("flip_back", {31'b0, back_sel}, 32'd0);
        chk("flip_fc", {16'b0, frame_count}, 32'd1);
        @(negedge clk);
        chk("flip_pulse", writedata, 32'h0);
        chk("flip_done", {31'b0, flip_pending}, 32'd0);
        vcount = 10'd100;

        // flip then write, from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_back", {31'b0, back_sel}, 32'd1);
        cmd_in = 32'h001E0000; cmd_in_valid = 1'b1;
        @(negedge clk);
        cmd_in = 32'h28024000;
        @(negedge clk);
        cmd_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("fw_pend", {31'b0, flip_pending}, 32'd1);
        chk("fw_level", {27'b0, fifo_level}, 32'd1);
        chk("fw_wd", writedata, 32'h0);
        vcount = 10'd480;
        wait_wd(ok);
        chk("fw_seen", {31'b0, ok}, 32'd1);
        chk("fw_flip", writedata, 32'h001E2000);
        @(negedge clk);
        chk("fw_write", writedata, 32'h28024000);
        @(negedge clk);
        chk("fw_idle", writedata, 32'h0);
        chk("fw_fc", {16'b0, frame_count}, 32'd1);
        vcount = 10'd100;

        // fill while waiting, overflow, clear, drain
        @(negedge clk);
        cmd_in = 32'h001E0000; cmd_in_valid = 1'b1;
        @(negedge clk);
        cmd_in_valid = 1'b0;
        @(negedge clk);
        chk("of_pend", {31'b0, flip_pending}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            cmd_in = 32'h28020000 | 32'(i);
            cmd_in_valid = 1'b1;
            @(negedge clk);
        end
        chk("of_level16", {27'b0, fifo_level}, 32'd16);
        chk("of_ready0", {31'b0, cmd_in_ready}, 32'd0);
        chk("of_ovf0", {31'b0, overflow}, 32'd0);
        cmd_in = 32'h28020010;
        @(negedge clk);
        chk("of_ovf1", {31'b0, overflow}, 32'd1);
        chk("of_level", {27'b0, fifo_level}, 32'd16);
`ifdef DROP_COUNT_EN
        chk("of_dcnt", {16'b0, drop_count}, 32'd1);
`endif
        clr_status = 1'b1;
        @(negedge clk);
        chk("of_clr_drop", {31'b0, overflow}, 32'd1);
        cmd_in_valid = 1'b0;
        @(negedge clk);
        chk("of_clr", {31'b0, overflow}, 32'd0);
        clr_status = 1'b0;
        vcount = 10'd480;
        wait_wd(ok);
        chk("of_seen", {31'b0, ok}, 32'd1);
        chk("of_flip", writedata, 32'h001E0000);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("of_drain", writedata, 32'h28022000 | 32'(i));
        end
        @(negedge clk);
        chk("of_idle", writedata, 32'h0);
        chk("of_empty", {27'b0, fifo_level}, 32'd0);
        chk("of_fc", {16'b0, frame_count}, 32'd2);
        chk("of_back", {31'b0, back_sel}, 32'd1);
        vcount = 10'd100;

        // reset while a flip is pending
        @(negedge clk);
        cmd_in = 32'h001E0000; cmd_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_in = 32'h28024000 | 32'(i);
        end
        @(negedge clk);
        cmd_in_valid = 1'b0;
        @(negedge clk);
        chk("rw_pend", {31'b0, flip_pending}, 32'd1);
        chk("rw_level", {27'b0, fifo_level}, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_level0", {27'b0, fifo_level}, 32'd0);
        chk("rw_pend0", {31'b0, flip_pending}, 32'd0);
        chk("rw_back", {31'b0, back_sel}, 32'd1);
        @(negedge clk);
        vcount = 10'd480;
        nz = 0;
        repeat (6) begin
            @(negedge clk);
            if (writedata !== 32'h0) nz++;
        end
        chk("rw_noflip", 32'(nz), 32'd0);
        chk("rw_fc", {16'b0, frame_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_cmd_scheduler.md
Name: frame_cmd_scheduler

Overview:
- Sits between the Avalon slave register and all sprite/tile display components on the shared 32-bit `writedata` command bus.
- Queues software command words in a FIFO and replays them one per clock.
- Forces every write to target the current back (hidden) ping-pong buffer.
- Holds each buffer-flip (commit) command until the start of vertical blanking, giving tear-free frame updates.

Parameters:
- FIFO_DEPTH, 16, number of queued command words; must be a power of 2.
- ADDR_W, 4, log2(FIFO_DEPTH).
- VBLANK_LINE, 480, first vcount value of vertical blanking.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_in  in  32  command word from software: sub_comp[31:26], child[25:21], info[20:17], type[16:14], pp[13], msg[12:0].
- cmd_in_valid  in  1  one-cycle write strobe for cmd_in.
- cmd_in_ready  out  1  high when FIFO not full.
- hcount  in  10  current VGA pixel column.
- vcount  in  10  current VGA line.
- clr_status  in  1  clears the overflow flag.
- writedata  out  32  registered command word broadcast to display components.
- back_sel  out  1  index of the buffer currently being written (hidden).
- flip_pending  out  1  high while in WAIT_VBL.
- fifo_level  out  ADDR_W+1  number of queued words.
- overflow  out  1  sticky; set when a write is dropped.
- frame_count  out  16  number of flips issued, wraps.

Behaviour:
- Reset values (asynchronous):
  - writedata=0, back_sel=1, flip_pending=0, fifo_level=0, overflow=0, frame_count=0.
  - FSM=RUN, FIFO empty, vblank edge register=0.
- Idle bus: writedata=0 means info=0000, a no-op for all components. Every emitted command is a single-cycle pulse; writedata returns to 0 the following cycle unless another command is emitted.
- Push filter, on cmd_in_valid:
  - Only info=0001 (write) and info=1111 (flip) words are queued.
  - Any other info value is discarded silently; overflow is not set.
- Push when full:
  - cmd_in_ready = !full, evaluated at the start of the cycle.
  - A push while full is dropped and sets overflow. A simultaneous pop does not rescue it.
- clr_status clears overflow. If clr_status and a drop occur in the same cycle, overflow stays set.
- Latency: a word pushed at edge E is popped at edge E+1 and drives writedata during the cycle after E+1 (minimum 2 cycles). Throughput is 1 word/cycle.
- vblank_start: a one-cycle pulse on the rising edge of (vcount >= VBLANK_LINE), from a registered compare.
- FSM:
  - RUN:
    - FIFO empty: writedata=0.
    - Head is info=0001: pop it and emit it with bit13 replaced by back_sel.
    - Head is info=1111: pop it, emit nothing, go to WAIT_VBL.
  - WAIT_VBL: flip_pending=1; no pops (later commands stay queued; pushes still accepted). On vblank_start, go to FLIP.
  - FLIP, one cycle:
    - Emit writedata = {6'b0, 5'b0, 4'b1111, 3'b0, back_sel, 13'b0}. The bus flip makes back_sel the displayed buffer; display components clear the other buffer.
    - Toggle back_sel and increment frame_count.
    - Return to RUN.
- A flip reaching the head while already inside blanking still waits for the next vblank_start; the worst case is one frame.
- Back-to-back commits flip on consecutive frames, never two per frame.
- Reset asserted in any state, including WAIT_VBL:
  - Abandons the pending flip and empties the FIFO.
  - Display component state is not reset; software rebuilds both buffers.
- fifo_level reflects pushes/pops of the previous edge. Simultaneous push and pop leaves it unchanged.

Optional Feature:
- Macro DROP_COUNT_EN.
- Defined: adds output port drop_count (16 bits). It saturates at 0xFFFF, increments on each dropped push, and is cleared by reset and clr_status.
- Undefined: the port is absent; only the sticky overflow flag exists.

Test Plan:
- Reset pulse mid-frame -> writedata=0x00000000, back_sel=1, cmd_in_ready=1, fifo_level=0, frame_count=0.
- Push 0x28024000, 0x28028000, 0x2802C000 on consecutive cycles (vcount=100) -> the same words with bit13=1 (0x28026000, 0x2802A000, 0x2802E000) appear on writedata on 3 consecutive cycles, starting 2 cycles after the first push.
- Push flip word 0x001E0000 at vcount=100 -> flip_pending=1, writedata stays 0. On vcount 479->480, writedata=0x001E2000 for exactly one cycle, then back_sel=0 and frame_count=1.
- Push flip then 0x28024000 while vcount=100 -> the write is held until after the flip, then emitted as 0x28024000 (bit13=0).
- While in WAIT_VBL, push 17 valid writes -> after 16, cmd_in_ready=0 and fifo_level=16; the 17th sets overflow=1 (drop_count=1 if enabled). clr_status clears overflow; all 16 drain after the flip.
- Assert reset during WAIT_VBL with 5 queued -> next cycle fifo_level=0, flip_pending=0, back_sel=1; no flip word appears at the following vblank.
